miller_frame_deframer: RTL and testbench
========================================

Name: miller_frame_deframer

Overview:
- Downstream neighbour of mill_modif_demod in the ISO14443A PCD→PICC receive path at 106 kbps.
- Consumes the decoder's serial bit (out_data) and its pause indicator, and recovers ETU timing.
- Detects SOF and EOF, and assembles 8-bit bytes LSB-first with the odd parity bit checked.
- Outputs byte strobes, a short-frame flag (7-bit REQA/WUPA) and end-of-frame status to the protocol layer.

Parameters:
- ETU_CLKS, 32, clk cycles per ETU (3.39 MHz / 106 kHz).
- SAMPLE_PT, 16, ETU counter value at which in_data is sampled.
- SKIP_BITS, 1, sampled bits discarded after SOF (decoder 1-ETU latency).
- IDLE_CLKS, 64, clk cycles without a pause rising edge that declare EOF.
- EOF_DROP, 1, trailing sampled bits discarded at EOF (the EOF logic-0).

Ports:
- clk  in  1  system clock, 3.39 MHz
- rst_n  in  1  synchronous active-low reset
- in_enable  in  1  receive enable; low aborts any frame
- in_data  in  1  decoded serial bit from mill_modif_demod.out_data
- pause  in  1  modulation pause indicator, high during pause
- out_byte  out  8  assembled byte; short frame is {1'b0, 7 bits}
- out_valid  out  1  1-cycle strobe, out_byte/parity_err valid
- parity_err  out  1  odd-parity failure for current out_byte
- short_frame  out  1  qualifies out_valid: 7-bit frame
- frame_done  out  1  1-cycle pulse at EOF
- frame_err  out  1  valid with frame_done: residual bits not 0 and not short frame

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all counters 0, every output 0.
- Reset is synchronous only.
- pause rising edge: detected from a 1-flop delayed copy of pause.
- States and transitions:
  - IDLE: stays here until a pause rising edge with in_enable=1. That edge is SOF: ETU counter←0, idle counter←0, skip counter←SKIP_BITS, go to RX.
  - RX: ETU counter wraps at ETU_CLKS-1. At count==SAMPLE_PT, in_data is sampled.
    - While skip>0, the sample is discarded and skip is decremented.
    - Otherwise the bit is pushed into a 9-entry history and bit_idx (0..8) is incremented.
    - On every pause rising edge in RX: ETU counter←0 (re-align) and idle counter←0.
    - Idle counter saturates at IDLE_CLKS.
  - Byte completion: sample with bit_idx==8 is the parity bit.
    - Next clk: out_valid=1, out_byte=bits 0..7 (first received = bit 0).
    - parity_err=~(^{data,parity}).
    - bit_idx←0 and byte_cnt is incremented (8-bit, saturating).
  - EOF: idle counter reaches IDLE_CLKS → go to DONE. No sample is taken on that clk.
  - DONE (one cycle):
    - The last EOF_DROP pushed bits are discarded: residual r = bit_idx − EOF_DROP, floored at 0.
    - If byte_cnt==0 and r==7: out_valid=1, short_frame=1, out_byte={0, 7 bits}, parity_err=0, frame_err=0.
    - Else frame_err=(r!=0).
    - frame_done=1 in the same cycle. Then go to IDLE.
- EOF_DROP bookkeeping: a parity bit counted in a completed byte that falls within the dropped tail is not revoked. The protocol layer tolerates this.
- in_enable=0 in RX: immediate return to IDLE. No out_valid or frame_done. Partial data discarded.
- Simultaneous pause edge and SAMPLE_PT: sample first, then counter realign.
- Simultaneous byte completion and EOF: the byte strobe is issued first; DONE follows on the next clk.
- out_valid, frame_done: single-cycle pulses, never asserted while in IDLE except the DONE cycle.
- Latency: out_valid is 1 clk after the parity sample.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RX, DONE)
  - ETU_CLKS and IDLE_CLKS defaults
  - short-frame length constant 7
  - ISO14443A command constants (REQA=7'h26, WUPA=7'h52)
- Natural sub-module miller_etu_timer: ETU counter, pause edge detect, idle counter, sample strobe.
- Byte assembly and the FSM stay in the top.

Test Plan:
- Bench model drives pause at each modulated bit edge and in_data one ETU late.
- REQA: in_enable=1, SOF, bits 0,1,1,0,0,1,0, EOF logic-0, idle → out_valid with short_frame=1, out_byte=8'h26, then frame_done=1, frame_err=0.
- Byte 0x93 (bits 1,1,0,0,1,0,0,1), parity 1 → out_valid, out_byte=8'h93, parity_err=0; frame_done, frame_err=0.
- Same byte with parity 0 → out_byte=8'h93, parity_err=1.
- Two bytes 0x93,0x20 with correct parity → two out_valid strobes 9 ETUs apart, byte order preserved, one frame_done.
- Frame with 4 residual bits after one byte → frame_done=1, frame_err=1, no extra out_valid.
- in_enable dropped mid-byte → no outputs; next SOF decodes 0x26 correctly.
- rst_n low for 1 clk mid-frame → all outputs 0, back in IDLE.

Source files
------------

// File: rtl/miller_frame_deframer_pkg.sv
// rtl/miller_frame_deframer_pkg.sv - shared types and constants for the Miller frame deframer
// Purpose: FSM state enum, timing defaults, short-frame length and ISO14443A
//          short-frame command codes shared by the deframer and its ETU timer.
// Ports:   none (package)
package miller_frame_deframer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ETU_CLKS_DEF  = 32;
  localparam int SAMPLE_PT_DEF = 16;
  localparam int SKIP_BITS_DEF = 1;
  localparam int IDLE_CLKS_DEF = 64;
  localparam int EOF_DROP_DEF  = 1;

  localparam logic [3:0] SHORT_LEN = 4'd7;

  localparam logic [6:0] CMD_REQA = 7'h26;
  localparam logic [6:0] CMD_WUPA = 7'h52;

endpackage

// File: rtl/miller_etu_timer.sv
// rtl/miller_etu_timer.sv - ETU timing recovery for the Miller frame deframer
// Purpose: pause rising-edge detect, ETU counter re-aligned on every pause edge,
//          saturating idle counter and the per-ETU sample strobe.
// Ports:   clk, rst_n      - clock, synchronous active-low reset
//          i_pause         - modulation pause indicator
//          i_run           - high while a frame is being received
//          o_pause_rise    - pause rising edge this cycle
//          o_sample        - sample in_data this cycle
//          o_eof           - idle counter has reached IDLE_CLKS
module miller_etu_timer
  import miller_frame_deframer_pkg::*;
#(
  parameter int ETU_CLKS  = ETU_CLKS_DEF,
  parameter int SAMPLE_PT = SAMPLE_PT_DEF,
  parameter int IDLE_CLKS = IDLE_CLKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pause,
  input  logic i_run,
  output logic o_pause_rise,
  output logic o_sample,
  output logic o_eof
);

  localparam int EW = $clog2(ETU_CLKS);
  localparam int IW = $clog2(IDLE_CLKS + 1);
  localparam logic [EW-1:0] ETU_LAST  = EW'(ETU_CLKS - 1);
  localparam logic [EW-1:0] SAMPLE_AT = EW'(SAMPLE_PT);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CLKS);

  logic          r_pause_d;
  logic [EW-1:0] r_etu;
  logic [IW-1:0] r_idle;
  logic          w_rise;

  assign w_rise       = i_pause & ~r_pause_d;
  assign o_pause_rise = w_rise;
  // Sample uses the pre-realign count, so a coincident pause edge samples first.
  assign o_sample     = i_run & (r_etu == SAMPLE_AT);
  assign o_eof        = i_run & (r_idle == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pause_d <= 1'b0;
      r_etu     <= '0;
      r_idle    <= '0;
    end else begin
      r_pause_d <= i_pause;
      // Outside a frame the counters sit at 0, so SOF starts them from 0.
      if (!i_run || w_rise) begin
        r_etu  <= '0;
        r_idle <= '0;
      end else begin
        r_etu <= (r_etu == ETU_LAST) ? '0 : r_etu + 1'b1;
        if (r_idle != IDLE_MAX) r_idle <= r_idle + 1'b1;
      end
    end
  end

endmodule

// File: rtl/miller_frame_deframer.sv
// rtl/miller_frame_deframer.sv - ISO14443A 106 kbps PCD->PICC frame deframer
// Purpose: SOF/EOF detection and LSB-first byte assembly with odd-parity check
//          on the serial output of the modified-Miller decoder.
// Ports:   clk, rst_n        - clock, synchronous active-low reset
//          in_enable         - receive enable, low aborts a frame
//          in_data, pause    - decoded bit and pause indicator
//          out_byte/out_valid/parity_err/short_frame - byte strobe and status
//          frame_done/frame_err                      - end-of-frame pulse and status
module miller_frame_deframer
  import miller_frame_deframer_pkg::*;
#(
  parameter int ETU_CLKS  = ETU_CLKS_DEF,
  parameter int SAMPLE_PT = SAMPLE_PT_DEF,
  parameter int SKIP_BITS = SKIP_BITS_DEF,
  parameter int IDLE_CLKS = IDLE_CLKS_DEF,
  parameter int EOF_DROP  = EOF_DROP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_enable,
  input  logic       in_data,
  input  logic       pause,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       parity_err,
  output logic       short_frame,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [3:0] SKIP_INIT = 4'(SKIP_BITS);
  localparam logic [3:0] DROP      = 4'(EOF_DROP);

  state_e     r_state;
  logic [3:0] r_skip;
  logic [3:0] r_bit_idx;
  logic [7:0] r_hist;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_out_byte;
  logic       r_out_valid;
  logic       r_parity_err;
  logic       r_short_frame;
  logic       r_frame_done;
  logic       r_frame_err;

  logic       w_rise;
  logic       w_sample;
  logic       w_eof;
  logic [3:0] w_resid;

  miller_etu_timer #(
    .ETU_CLKS  (ETU_CLKS),
    .SAMPLE_PT (SAMPLE_PT),
    .IDLE_CLKS (IDLE_CLKS)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pause      (pause),
    .i_run        (r_state == ST_RX),
    .o_pause_rise (w_rise),
    .o_sample     (w_sample),
    .o_eof        (w_eof)
  );

  // Trailing EOF logic-0 bits are not data; floor at 0 when fewer were pushed.
  assign w_resid = (r_bit_idx > DROP) ? (r_bit_idx - DROP) : 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_skip        <= '0;
      r_bit_idx     <= '0;
      r_hist        <= '0;
      r_byte_cnt    <= '0;
      r_out_byte    <= '0;
      r_out_valid   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_short_frame <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_short_frame <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && in_enable) begin
            r_state    <= ST_RX;
            r_skip     <= SKIP_INIT;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_RX: begin
          if (!in_enable) begin
            r_state <= ST_IDLE;
          end else if (w_eof) begin
            // EOF cycle takes no sample; DONE outputs are registered here.
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
            if (r_byte_cnt == 8'd0 && w_resid == SHORT_LEN) begin
              r_out_valid   <= 1'b1;
              r_short_frame <= 1'b1;
              r_out_byte    <= {1'b0, r_hist[6:0]};
              r_parity_err  <= 1'b0;
            end else begin
              r_frame_err <= (w_resid != 4'd0);
            end
          end else if (w_sample) begin
            if (r_skip != 4'd0) begin
              r_skip <= r_skip - 4'd1;
            end else if (r_bit_idx == 4'd8) begin
              // Ninth bit is the parity bit; it is checked directly, not stored.
              r_out_valid  <= 1'b1;
              r_out_byte   <= r_hist;
              r_parity_err <= ~(^{r_hist, in_data});
              r_bit_idx    <= '0;
              if (r_byte_cnt != 8'hFF) r_byte_cnt <= r_byte_cnt + 8'd1;
            end else begin
              r_hist[r_bit_idx[2:0]] <= in_data;
              r_bit_idx              <= r_bit_idx + 4'd1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_byte    = r_out_byte;
  assign out_valid   = r_out_valid;
  assign parity_err  = r_parity_err;
  assign short_frame = r_short_frame;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_miller_frame_deframer.sv
// tb/tb_miller_frame_deframer.sv - self-checking bench for miller_frame_deframer
module tb_miller_frame_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_enable;
  logic       in_data;
  logic       pause;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       parity_err;
  logic       short_frame;
  logic       frame_done;
  logic       frame_err;

  always #5 clk = ~clk;

  miller_frame_deframer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_enable   (in_enable),
    .in_data     (in_data),
    .pause       (pause),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .parity_err  (parity_err),
    .short_frame (short_frame),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  typedef struct {
    logic       is_done;
    logic [7:0] byte_v;
    logic       perr;
    logic       shrt;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  logic tx[$];
  int   valid_cyc[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t e;
  logic got_ok;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic pe, input logic sh);
    exp_t x;
    x.is_done = 1'b0; x.byte_v = b; x.perr = pe; x.shrt = sh; x.ferr = 1'b0;
    sb.push_back(x);
  endtask

  task automatic exp_done(input logic fe);
    exp_t x;
    x.is_done = 1'b1; x.byte_v = 8'h00; x.perr = 1'b0; x.shrt = 1'b0; x.ferr = fe;
    sb.push_back(x);
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      got_ok = (sb.size() != 0) && !sb[0].is_done;
      total++;
      assert (got_ok) else begin
        bad++;
        $error("FAIL unexpected_out_valid observed=%0h expected=none", out_byte);
      end
      if (got_ok) begin
        e = sb.pop_front();
        total++;
        assert ({out_byte, parity_err, short_frame} === {e.byte_v, e.perr, e.shrt}) else begin
          bad++;
          $error("FAIL byte observed=%0h/pe%0b/sf%0b expected=%0h/pe%0b/sf%0b",
                 out_byte, parity_err, short_frame, e.byte_v, e.perr, e.shrt);
        end
      end
    end
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      got_ok = (sb.size() != 0) && sb[0].is_done;
      total++;
      assert (got_ok) else begin
        bad++;
        $error("FAIL unexpected_frame_done observed=%0b expected=none", frame_err);
      end
      if (got_ok) begin
        e = sb.pop_front();
        total++;
        assert (frame_err === e.ferr) else begin
          bad++;
          $error("FAIL frame_err observed=%0b expected=%0b", frame_err, e.ferr);
        end
      end
    end
  end

  // One ETU of decoder output: pause marks the ETU start, in_data is stable all ETU.
  task automatic send_etu(input logic p, input logic d);
    in_data = d;
    pause   = p;
    repeat (4) @(posedge clk);
    #1 pause = 1'b0;
    repeat (28) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic par);
    for (int i = 0; i < 8; i++) tx.push_back(b[i]);
    tx.push_back(par);
  endtask

  // SOF ETU, one ETU per bit in tx, unmodulated EOF logic-0, then idle.
  task automatic send_frame();
    send_etu(1'b1, 1'b0);
    foreach (tx[i]) send_etu(1'b1, tx[i]);
    send_etu(1'b0, 1'b0);
    in_data = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    tx.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] reqa;
    reqa      = 7'h26;
    rst_n     = 1'b0;
    in_enable = 1'b0;
    in_data   = 1'b0;
    pause     = 1'b0;
    idle(3);
    check("reset_byte", 16'(out_byte), 16'h0);
    check("reset_flags", 16'({out_valid, parity_err, short_frame, frame_done, frame_err}), 16'h0);
    rst_n = 1'b1;
    in_enable = 1'b1;
    idle(5);

    // REQA short frame
    for (int i = 0; i < 7; i++) tx.push_back(reqa[i]);
    exp_byte(8'h26, 1'b0, 1'b1);
    exp_done(1'b0);
    send_frame();
    check("reqa_pending", 16'(sb.size()), 16'd0);

    // 0x93 with correct parity
    push_byte(8'h93, odd_par(8'h93));
    exp_byte(8'h93, 1'b0, 1'b0);
    exp_done(1'b0);
    send_frame();
    check("b93_pending", 16'(sb.size()), 16'd0);

    // 0x93 with wrong parity
    push_byte(8'h93, ~odd_par(8'h93));
    exp_byte(8'h93, 1'b1, 1'b0);
    exp_done(1'b0);
    send_frame();
    check("b93_bad_pending", 16'(sb.size()), 16'd0);

    // Two bytes, strobes 9 ETUs apart
    valid_cyc.delete();
    push_byte(8'h93, odd_par(8'h93));
    push_byte(8'h20, odd_par(8'h20));
    exp_byte(8'h93, 1'b0, 1'b0);
    exp_byte(8'h20, 1'b0, 1'b0);
    exp_done(1'b0);
    send_frame();
    check("two_pending", 16'(sb.size()), 16'd0);
    check("two_strobes", 16'(valid_cyc.size()), 16'd2);
    if (valid_cyc.size() == 2)
      check("two_gap", 16'(valid_cyc[1] - valid_cyc[0]), 16'd288);

    // One byte plus 4 residual bits
    push_byte(8'h93, odd_par(8'h93));
    tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b0);
    exp_byte(8'h93, 1'b0, 1'b0);
    exp_done(1'b1);
    send_frame();
    check("resid_pending", 16'(sb.size()), 16'd0);

    // Enable dropped mid-byte, then a clean REQA
    send_etu(1'b1, 1'b0);
    send_etu(1'b1, 1'b0);
    send_etu(1'b1, 1'b1);
    in_enable = 1'b0;
    send_etu(1'b1, 1'b1);
    send_etu(1'b1, 1'b0);
    idle(150);
    check("abort_silent", 16'(sb.size()), 16'd0);
    in_enable = 1'b1;
    idle(5);
    for (int i = 0; i < 7; i++) tx.push_back(reqa[i]);
    exp_byte(8'h26, 1'b0, 1'b1);
    exp_done(1'b0);
    send_frame();
    check("after_abort_pending", 16'(sb.size()), 16'd0);

    // Reset for one clock in the middle of the second byte
    push_byte(8'h93, odd_par(8'h93));
    exp_byte(8'h93, 1'b0, 1'b0);
    send_etu(1'b1, 1'b0);
    foreach (tx[i]) send_etu(1'b1, tx[i]);
    tx.delete();
    send_etu(1'b1, 1'b1);
    send_etu(1'b1, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midreset_byte", 16'(out_byte), 16'h0);
    check("midreset_flags", 16'({out_valid, parity_err, short_frame, frame_done, frame_err}), 16'h0);
    idle(150);
    check("midreset_silent", 16'(sb.size()), 16'd0);
    push_byte(8'h20, odd_par(8'h20));
    exp_byte(8'h20, 1'b0, 1'b0);
    exp_done(1'b0);
    send_frame();
    check("recover_pending", 16'(sb.size()), 16'd0);

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
